// File: rtl/terminal_pkg.sv
// Geometry and timing of the 80x40 text terminal.
// Shared by the sync generator, the text RAM and the cell renderer.
package terminal_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int COLS     = 80;
    localparam int ROWS     = 40;
    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 12;
    localparam int ADDR_W   = 12;
    localparam int POS_W    = 10;
    localparam int COL_W    = 7;
    localparam int ROW_W    = 6;
    localparam int YOFS_W   = 4;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [YOFS_W-1:0] yofs;
        logic [ADDR_W-1:0] row_base;
        logic              blank;
    } line_state_t;
endpackage

// File: rtl/cell_line_counter.sv
// Tracks text row, glyph row and the row's RAM base address for the line being fetched.
// Advances once per line at hpos H_TOTAL-4.
module cell_line_counter
    import terminal_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [POS_W-1:0]  hpos,
    input  logic [POS_W-1:0]  vpos,
    output logic [YOFS_W-1:0] yofs,
    output logic [ROW_W-1:0]  fetch_row,
    output logic [ADDR_W-1:0] fetch_base,
    output logic              fetch_blank
);
    line_state_t cur_r;
    line_state_t nxt_s;
    logic        line_end_s;

    assign line_end_s = (hpos == POS_W'(H_TOTAL - 4));
    assign yofs       = cur_r.yofs;

    // next-line state; row_base steps by COLS so no multiplier is needed
    always_comb begin
        nxt_s = cur_r;
        if (vpos == POS_W'(V_TOTAL - 1)) begin
            nxt_s = '0;
        end else begin
            nxt_s.blank = (vpos >= POS_W'(V_ACTIVE - 1));
            if (cur_r.yofs == YOFS_W'(CHAR_H - 1)) begin
                nxt_s.yofs     = 4'd0;
                nxt_s.row      = cur_r.row + 6'd1;
                nxt_s.row_base = cur_r.row_base + ADDR_W'(COLS);
            end else begin
                nxt_s.yofs     = cur_r.yofs + 4'd1;
            end
        end
    end

    // line state register, updated at the line end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_r <= '0;
        end else if (line_end_s) begin
            cur_r <= nxt_s;
        end
    end

    // the column-0 fetch shares the line-end clock, so it must see the advanced values
    always_comb begin
        if (line_end_s) begin
            fetch_row   = nxt_s.row;
            fetch_base  = nxt_s.row_base;
            fetch_blank = nxt_s.blank;
        end else begin
            fetch_row   = cur_r.row;
            fetch_base  = cur_r.row_base;
            fetch_blank = cur_r.blank;
        end
    end
endmodule

// File: rtl/text_cell_renderer.sv
// 80x40 character-cell renderer: prefetches each cell's code and glyph row, then
// shifts out one monochrome pixel per clock, with a blinking block cursor.
module text_cell_renderer
    import terminal_pkg::*;
#(
    parameter int BLINK_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [POS_W-1:0]  hpos,
    input  logic [POS_W-1:0]  vpos,
    input  logic              display_on,
    input  logic              cursor_en,
    input  logic [COL_W-1:0]  cursor_col,
    input  logic [ROW_W-1:0]  cursor_row,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [7:0]        text_data,
    output logic [7:0]        font_char,
    output logic [YOFS_W-1:0] font_yofs,
    input  logic [7:0]        font_bits,
    output logic              pixel
);
    localparam int FW = BLINK_BIT + 1;

    logic [YOFS_W-1:0] yofs_s;
    logic [ROW_W-1:0]  fetch_row_s;
    logic [ADDR_W-1:0] fetch_base_s;
    logic              fetch_blank_s;
    logic [COL_W-1:0]  fcol_s;
    logic              fetch_ok_s;
    logic              cell_valid_r;
    logic              is_cursor_r;
    logic              inv_r;
    logic [7:0]        shreg_r;
    logic [FW-1:0]     frame_r;

    cell_line_counter u_lines (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .yofs        (yofs_s),
        .fetch_row   (fetch_row_s),
        .fetch_base  (fetch_base_s),
        .fetch_blank (fetch_blank_s)
    );

    // fetched cell is the one whose pixels start at the next phase 0 (wraps to column 0)
    assign fcol_s     = (hpos[9:3] == COL_W'(H_TOTAL / CHAR_W - 1)) ? 7'd0 : hpos[9:3] + 7'd1;
    assign fetch_ok_s = (fcol_s < COL_W'(COLS)) && !fetch_blank_s;

    // cell pipeline: address, font lookup, glyph load and pixel shift-out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_addr    <= '0;
            font_char    <= 8'd0;
            font_yofs    <= 4'd0;
            pixel        <= 1'b0;
            cell_valid_r <= 1'b0;
            is_cursor_r  <= 1'b0;
            inv_r        <= 1'b0;
            shreg_r      <= 8'd0;
        end else begin
            pixel   <= (shreg_r[7] ^ inv_r) & display_on;
            shreg_r <= {shreg_r[6:0], 1'b0};
            case (hpos[2:0])
                3'd4: begin
                    cell_valid_r <= fetch_ok_s;
                    is_cursor_r  <= cursor_en && (fcol_s == cursor_col) && (fetch_row_s == cursor_row);
                    if (fetch_ok_s) begin
                        text_addr <= fetch_base_s + ADDR_W'(fcol_s);
                    end
                end
                3'd6: begin
                    font_char <= text_data;
                    font_yofs <= yofs_s;
                end
                3'd7: begin
                    shreg_r <= cell_valid_r ? font_bits : 8'd0;
                    inv_r   <= is_cursor_r & frame_r[BLINK_BIT];
                end
                default: begin
                end
            endcase
        end
    end

    // free-running frame counter, ticked once per frame at the start of vblank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_r <= '0;
        end else if (hpos == 10'd0 && vpos == POS_W'(V_ACTIVE)) begin
            frame_r <= frame_r + FW'(1);
        end
    end
endmodule

// File: tb/tb_text_cell_renderer.sv
// Randomised bench for text_cell_renderer with a screen-level reference model.
// Unchecked lines are compressed to their line-end clock to keep runs short.
module tb_text_cell_renderer;
    import terminal_pkg::*;

    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [7:0]  font_char;
    logic [3:0]  font_yofs;
    logic [7:0]  font_bits;
    logic        pixel;

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:4095];
    bit         cur_mask [0:524];
    bit         nxt_mask [0:524];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cur_h = 0;
    int         cur_v = 0;
    int         frame_cnt = 0;

    text_cell_renderer #(.BLINK_BIT(BLINK)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_char  (font_char),
        .font_yofs  (font_yofs),
        .font_bits  (font_bits),
        .pixel      (pixel)
    );

    always #20 clk = ~clk;
    assign font_bits = rom[{font_char, font_yofs}];
    always @(posedge clk) text_data <= ram[text_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s line %0d hpos %0d: got %0h expected %0h", tag, cur_v, cur_h, got, exp);
        end
    endtask

    // screen pixel x=h on line v, straight from the character grid
    function automatic logic exp_pixel(input int h, input int v);
        logic [7:0] ch;
        logic [7:0] bits;
        logic       b;
        int         col;
        int         row;
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 1'b0;
        col  = h / CHAR_W;
        row  = v / CHAR_H;
        ch   = ram[row * COLS + col];
        bits = rom[{ch, 4'(v % CHAR_H)}];
        b    = bits[7 - (h % CHAR_W)];
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && ((frame_cnt >> BLINK) & 1) == 1)
            b = ~b;
        return b;
    endfunction

    task automatic step(input int h, input int v, input bit chk);
        int tv;
        int c;
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = (h < H_ACTIVE) && (v < V_ACTIVE);
        cur_h = h;
        cur_v = v;
        @(posedge clk);
        if (h == 0 && v == V_ACTIVE && !reset) frame_cnt++;
        @(negedge clk);
        if (chk) begin
            check_eq("pixel", pixel, exp_pixel(h, v));
            check_eq("addr_range", text_addr <= 12'd3199, 1);
            tv = (h >= H_TOTAL - 4) ? (v + 1) % V_TOTAL : v;
            c  = ((h + 4) % H_TOTAL) / CHAR_W;
            if (c < COLS && tv < V_ACTIVE) begin
                if (h % 8 == 4) check_eq("text_addr", text_addr, (tv / CHAR_H) * COLS + c);
                if (h % 8 == 6) begin
                    check_eq("font_char", font_char, ram[(tv / CHAR_H) * COLS + c]);
                    check_eq("font_yofs", font_yofs, tv % CHAR_H);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pixel"}, pixel, 0);
        check_eq({tag, "_text_addr"}, text_addr, 0);
        check_eq({tag, "_font_char"}, font_char, 0);
        check_eq({tag, "_font_yofs"}, font_yofs, 0);
    endtask

    // content, cursor and checked lines for frame f
    task automatic setup(input int f);
        for (int i = 0; i < 3200; i++) ram[i] = (f == 1) ? 8'hFF : 8'($urandom);
        cursor_en  = 1'($urandom);
        cursor_col = 7'($urandom_range(0, 79));
        cursor_row = 6'($urandom_range(0, 39));
        if (f == 0 || f == 18) begin
            ram[0]      = 8'h41;
            cursor_en   = 1'b1;
            cursor_col  = 7'd3;
            cursor_row  = 6'd2;
            ram[2 * 80 + 3] = 8'h20;
        end
        if (f == 1) cursor_en = 1'b0;
        if (f == 19) begin
            cursor_en = 1'b1;
            ram[int'(cursor_row) * COLS + int'(cursor_col)] = 8'hB0;
        end
        for (int i = 0; i < V_TOTAL; i++) nxt_mask[i] = 1'b0;
        case (f)
            0: begin
                nxt_mask[0] = 1'b1;   nxt_mask[1] = 1'b1;   nxt_mask[11] = 1'b1;
                nxt_mask[12] = 1'b1;  nxt_mask[23] = 1'b1;  nxt_mask[24] = 1'b1;
                nxt_mask[35] = 1'b1;  nxt_mask[36] = 1'b1;  nxt_mask[479] = 1'b1;
                nxt_mask[480] = 1'b1; nxt_mask[524] = 1'b1;
            end
            1: begin
                nxt_mask[0] = 1'b1; nxt_mask[479] = 1'b1; nxt_mask[480] = 1'b1;
            end
            2: nxt_mask[50] = 1'b1;
            18: begin
                nxt_mask[0] = 1'b1;  nxt_mask[24] = 1'b1; nxt_mask[30] = 1'b1;
                nxt_mask[35] = 1'b1; nxt_mask[36] = 1'b1;
            end
            19: begin
                nxt_mask[0] = 1'b1;
                nxt_mask[int'(cursor_row) * CHAR_H + int'($urandom_range(0, 11))] = 1'b1;
            end
            default: nxt_mask[$urandom_range(0, 524)] = 1'b1;
        endcase
    endtask

    task automatic reset_mid_line(input int v);
        for (int h = 0; h < 20; h++) step(h, v, 1'b0);
        #3 reset = 1'b1;
        #1 check_zero("mid_reset");
        for (int h = 20; h < 24; h++) begin
            step(h, v, 1'b0);
            check_zero("held_reset");
        end
        reset = 1'b0;
        frame_cnt = 0;
        for (int h = 24; h < H_TOTAL; h++) step(h, v, 1'b0);
    endtask

    initial begin
        bit look;
        reset = 1'b1;
        hpos = 10'd0;
        vpos = 10'd0;
        display_on = 1'b0;
        cursor_en = 1'b0;
        cursor_col = 7'd0;
        cursor_row = 6'd0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'd0;
            rom[i] = 8'($urandom);
        end
        rom[{8'h41, 4'h0}] = 8'h81;
        for (int r = 0; r < 16; r++) begin
            rom[{8'h20, 4'(r)}] = 8'h00;
            rom[{8'hB0, 4'(r)}] = 8'hF0;
            rom[{8'hFF, 4'(r)}] = 8'hFF;
        end
        setup(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        for (int h = H_TOTAL - 8; h < H_TOTAL; h++) step(h, V_TOTAL - 1, 1'b0);
        for (int f = 0; f < 20; f++) begin
            cur_mask = nxt_mask;
            for (int v = 0; v < V_TOTAL; v++) begin
                if (v == 500) setup(f + 1);
                look = (v == V_TOTAL - 1) ? nxt_mask[0] : cur_mask[v + 1];
                if (f == 2 && v == 100) begin
                    reset_mid_line(v);
                end else if (cur_mask[v]) begin
                    for (int h = 0; h < H_TOTAL; h++) step(h, v, 1'b1);
                end else begin
                    if (v == V_ACTIVE) step(0, v, 1'b0);
                    if (look) begin
                        for (int h = H_TOTAL - 8; h < H_TOTAL; h++) step(h, v, 1'b0);
                    end else begin
                        step(H_TOTAL - 4, v, 1'b0);
                    end
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
